// File: rtl/fmap_bram_reader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fmap_bram_reader : streams `length` consecutive BRAM words out as valid/ready,
// absorbing read latency and backpressure via a credit-limited FIFO.
// Optional macro FMAP_RD_STRIDE_EN adds a `stride` input (address step).
// Revision: 1.0
// ----------------------------------------------------------------------------
module fmap_bram_reader #(
  parameter int DW    = 16,
  parameter int DEPTH = 1024,
  parameter int AW    = (DEPTH <= 1) ? 1 : $clog2(DEPTH),
  parameter int FD    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [AW-1:0]        base,
`ifdef FMAP_RD_STRIDE_EN
  input  logic [AW-1:0]        stride,
`endif
  input  logic [AW:0]          length,
  output logic                 busy,
  output logic                 done,
  output logic                 b_en,
  output logic [AW-1:0]        b_addr,
  input  logic signed [DW-1:0] b_dout,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic signed [DW-1:0] m_data,
  output logic                 m_last
);

  localparam int          PW     = $clog2(FD);
  localparam logic [PW:0] FD_CNT = (PW+1)'(FD);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               state;
  logic [AW:0]          len_q;
  logic [AW:0]          issued;
  logic [AW:0]          issued_nxt;
  logic [AW-1:0]        step;
  logic [PW:0]          resv;
  logic [PW:0]          resv_nxt;
  logic [PW:0]          count;
  logic                 cap_valid;
  logic                 cap_last;
  logic [PW-1:0]        wptr;
  logic [PW-1:0]        rptr;
  logic signed [DW-1:0] data_mem [FD];
  logic                 last_mem [FD];
  logic                 pop;
  logic                 final_pop;

  assign m_valid   = (count != '0);
  assign pop       = m_valid & m_ready;
  assign m_data    = data_mem[rptr];
  assign m_last    = m_valid & last_mem[rptr];
  assign final_pop = pop & m_last;

  // resv covers FIFO occupancy plus the read in flight, so a push always has room
  always_comb begin
    resv_nxt   = resv + (PW+1)'(b_en) - (PW+1)'(pop);
    issued_nxt = issued + (AW+1)'(b_en);
  end

`ifdef FMAP_RD_STRIDE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step <= '0;
    end else if (state == IDLE && start) begin
      step <= stride;
    end
  end
`else
  assign step = AW'(1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      b_en      <= 1'b0;
      b_addr    <= '0;
      len_q     <= '0;
      issued    <= '0;
      resv      <= '0;
      cap_valid <= 1'b0;
      cap_last  <= 1'b0;
    end else begin
      done      <= 1'b0;
      cap_valid <= b_en;
      cap_last  <= b_en && (issued == len_q - (AW+1)'(1));
      case (state)
        IDLE: begin
          if (start) begin
            if (length != '0) begin
              state  <= RUN;
              busy   <= 1'b1;
              len_q  <= length;
              issued <= '0;
              resv   <= '0;
              b_addr <= base;
              b_en   <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          resv   <= resv_nxt;
          issued <= issued_nxt;
          if (b_en) begin
            b_addr <= b_addr + step;
          end
          if (final_pop) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            b_en  <= 1'b0;
          end else begin
            b_en <= (issued_nxt < len_q) && (resv_nxt < FD_CNT);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < FD; i++) begin
        data_mem[i] <= '0;
        last_mem[i] <= 1'b0;
      end
    end else begin
      if (cap_valid) begin
        data_mem[wptr] <= b_dout;
        last_mem[wptr] <= cap_last;
        wptr           <= wptr + PW'(1);
      end
      if (pop) begin
        rptr <= rptr + PW'(1);
      end
      count <= count + (PW+1)'(cap_valid) - (PW+1)'(pop);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fmap_bram_reader.sv
`default_nettype none
`timescale 1ns/1ps
// tb_fmap_bram_reader : directed + randomized transfers checked against a
// queue-based model of the expected address and data streams.
module tb_fmap_bram_reader;
  localparam int DW    = 16;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int FD    = 4;

  logic                 clk    = 1'b0;
  logic                 rst_n  = 1'b0;
  logic                 start  = 1'b0;
  logic [AW-1:0]        base   = '0;
`ifdef FMAP_RD_STRIDE_EN
  logic [AW-1:0]        stride = '0;
`endif
  logic [AW:0]          length = '0;
  logic                 busy, done, b_en, m_valid, m_last;
  logic                 m_ready = 1'b1;
  logic [AW-1:0]        b_addr;
  logic signed [DW-1:0] b_dout = '0;
  logic signed [DW-1:0] m_data;
  logic signed [DW-1:0] mem [DEPTH];

  int tests = 0;
  int fails = 0;
  int rdy_mode = 0;
  int rdy_phase = 0;

  always #5 clk = ~clk;

  fmap_bram_reader #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .FD(FD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .base    (base),
`ifdef FMAP_RD_STRIDE_EN
    .stride  (stride),
`endif
    .length  (length),
    .busy    (busy),
    .done    (done),
    .b_en    (b_en),
    .b_addr  (b_addr),
    .b_dout  (b_dout),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last)
  );

  // BRAM read port: one cycle latency
  always @(posedge clk) begin
    if (b_en) b_dout <= mem[b_addr];
  end

  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       begin m_ready = (rdy_phase % 3 == 0); rdy_phase++; end
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"},   64'(busy),    64'(0));
    chk({tag, "_done"},   64'(done),    64'(0));
    chk({tag, "_b_en"},   64'(b_en),    64'(0));
    chk({tag, "_valid"},  64'(m_valid), 64'(0));
    chk({tag, "_last"},   64'(m_last),  64'(0));
    chk({tag, "_b_addr"}, 64'(b_addr),  64'(0));
    chk({tag, "_m_data"}, 64'(m_data),  64'(0));
  endtask

  task automatic xfer(input logic [AW-1:0] b, input logic [AW:0] len, input logic [AW-1:0] st,
                      input int rmode, input int abort_at, input bit poke);
    logic signed [DW-1:0] got_d[$];
    bit                   got_l[$];
    logic [AW-1:0]        got_a[$];
    logic signed [DW-1:0] prev_d = '0;
    bit                   prev_stall = 1'b0;
    int cyc = 0, first_en = -1, first_v = -1, last_hs = -1, done_cyc = -1, done_cnt = 0;
    int outst = 0, max_out = 0, unstable = 0, bad_busy = 0, late_en = 0;
    int step, n;
    logic [AW-1:0] ea;
`ifdef FMAP_RD_STRIDE_EN
    step = int'(st);
`else
    step = 1;
`endif
    rdy_mode = rmode;
    rdy_phase = 0;
    @(posedge clk); #1;
    start = 1'b1; base = b; length = len;
`ifdef FMAP_RD_STRIDE_EN
    stride = st;
`endif
    @(posedge clk); #1;
    start = 1'b0;
    base = AW'($urandom);
    length = (AW+1)'($urandom_range(1, DEPTH));
`ifdef FMAP_RD_STRIDE_EN
    stride = AW'($urandom);
`endif
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (b_en) begin
        got_a.push_back(b_addr);
        outst++;
        if (first_en < 0) first_en = cyc;
        if (done_cyc >= 0) late_en++;
      end
      if (outst > max_out) max_out = outst;
      if (prev_stall && m_valid && m_data !== prev_d) unstable++;
      prev_stall = m_valid && !m_ready;
      prev_d = m_data;
      if (m_valid && first_v < 0) first_v = cyc;
      if (m_valid && m_ready) begin
        got_d.push_back(m_data);
        got_l.push_back(m_last);
        outst--;
        last_hs = cyc;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (busy !== (len != 0 && done_cyc < 0)) bad_busy++;
      if (poke && cyc == 4) begin start = 1'b1; base = AW'($urandom); length = (AW+1)'(8); end
      if (poke && cyc == 5) start = 1'b0;
      if (abort_at > 0 && got_d.size() == abort_at) break;
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
    end

    n = (got_d.size() < int'(len)) ? got_d.size() : int'(len);
    for (int k = 0; k < n; k++) begin
      ea = AW'((int'(b) + k * step) % DEPTH);
      chk("data", 64'(got_d[k]), 64'(mem[ea]));
      chk("last", 64'(got_l[k]), 64'(k == int'(len) - 1));
    end

    if (abort_at > 0) begin
      rst_n = 1'b0;
      #1;
      chk_idle_outputs("async_rst");
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_idle_outputs("held_rst");
      rst_n = 1'b1;
      return;
    end

    chk("n_reads", 64'(got_a.size()), 64'(len));
    n = (got_a.size() < int'(len)) ? got_a.size() : int'(len);
    for (int k = 0; k < n; k++) begin
      chk("addr", 64'(got_a[k]), 64'((int'(b) + k * step) % DEPTH));
    end
    chk("n_words",     64'(got_d.size()), 64'(len));
    chk("done_count",  64'(done_cnt),     64'(1));
    chk("done_cycle",  64'(done_cyc),     (len != 0) ? 64'(last_hs + 1) : 64'(1));
    chk("busy_window", 64'(bad_busy),     64'(0));
    chk("reads_after_done", 64'(late_en), 64'(0));
    chk("resv_bound",  64'(max_out <= FD), 64'(1));
    chk("stall_stable", 64'(unstable),    64'(0));
    if (rmode == 0 && len != 0) begin
      chk("first_b_en_cycle",  64'(first_en), 64'(1));
      chk("first_valid_cycle", 64'(first_v),  64'(3));
      chk("last_hs_cycle",     64'(last_hs),  64'(int'(len) + 2));
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    xfer(AW'(16), (AW+1)'(4), AW'(1), 0, 0, 1'b0);
    xfer(AW'(16), (AW+1)'(4), AW'(1), 1, 0, 1'b0);

    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    xfer(AW'(DEPTH - 2), (AW+1)'(4), AW'(1), 0, 0, 1'b0);
    xfer(AW'($urandom), (AW+1)'(0), AW'(1), 0, 0, 1'b0);
    xfer(AW'($urandom), (AW+1)'(8), AW'(1), 2, 0, 1'b1);
    xfer(AW'(100), (AW+1)'(8), AW'(1), 0, 3, 1'b0);
    repeat (2) @(posedge clk);
    xfer(AW'(100), (AW+1)'(8), AW'(1), 0, 0, 1'b0);
    xfer(AW'($urandom), (AW+1)'(1), AW'(1), 0, 0, 1'b0);
    for (int t = 0; t < 6; t++) begin
      xfer(AW'($urandom), (AW+1)'($urandom_range(1, 40)), AW'(1), t % 3, 0, 1'b0);
    end
    xfer(AW'($urandom), (AW+1)'(DEPTH), AW'(1), 2, 0, 1'b0);
`ifdef FMAP_RD_STRIDE_EN
    xfer(AW'(5), (AW+1)'(3), AW'(3), 0, 0, 1'b0);
    xfer(AW'(5), (AW+1)'(3), AW'(0), 1, 0, 1'b0);
    xfer(AW'($urandom), (AW+1)'(20), AW'($urandom), 2, 0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
